ram_tracked: RTL and testbench
==============================

RAM_TRACKED -- requirements
Module: ram_tracked

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries (derived, not overridable).
REQ-003 SHALL have parameter RD_CLEAR, default 1, where 1 means an accepted read invalidates the entry and 0 means reads are non-destructive.
REQ-004 SHALL have parameter WR_FIRST, default 0, selecting same-address read/write collision behaviour (see REQ-016).
REQ-005 SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, reset that is synchronous and active-high.
REQ-007 SHALL have port wr_en, input, 1 bit, write request.
REQ-008 SHALL have port wr_addr, input, ADDR_W bits, write address.
REQ-009 SHALL have port wr_data, input, DATA_W bits, write data.
REQ-010 SHALL have port rd_en, input, 1 bit, read request.
REQ-011 SHALL have port rd_addr, input, ADDR_W bits, read address.
REQ-012 SHALL have port clr, input, 1 bit, invalidate-all command.
REQ-013 SHALL have port rd_data, output, DATA_W bits, read data, registered.
REQ-014 SHALL have output ports rd_valid (1 bit, read result present), rd_hit (1 bit, entry was valid), wr_overwrite (1 bit, pulse when a write hit a valid entry), count (ADDR_W+1 bits, number of valid entries), empty (1 bit) and full (1 bit).

Function
REQ-015 SHALL keep one valid bit per entry; a write stores wr_data and sets valid[wr_addr]; a write to a valid entry overwrites the data and pulses wr_overwrite=1 in the next cycle.
REQ-016 SHALL give reads a latency of 1: rd_en in cycle N -> rd_valid=1 in N+1, with rd_hit=valid[rd_addr], and rd_data=mem[rd_addr] when hit, else 0. On a same-address collision, WR_FIRST=1 returns wr_data with rd_hit=1, and WR_FIRST=0 returns the prior data and valid state.
REQ-017 SHALL set rd_valid=0 in N+1 when rd_en=0 in cycle N; rd_data and rd_hit then hold their last values.
REQ-018 SHALL clear valid[rd_addr] on an accepted read when RD_CLEAR=1, unless the same cycle writes the same address; in that case the write wins and the entry stays valid.
REQ-019 SHALL compute count_next = count + inc - dec, where inc = wr_en & !valid[wr_addr], and dec = rd_en & RD_CLEAR & valid[rd_addr] & !(wr_en & wr_addr==rd_addr); simultaneous write and read on different addresses apply both.
REQ-020 SHALL make count never exceed DEPTH and never underflow; this follows from REQ-019 with no saturation logic required.
REQ-021 SHALL derive empty=(count==0) and full=(count==DEPTH) combinationally from the count register, so they are consistent with count in every cycle.
REQ-022 SHALL treat clr=1 as follows: all valid bits clear and count=0 next cycle; wr_en/rd_en are ignored in that cycle (rd_valid=0, wr_overwrite=0 next cycle); memory data is not cleared.
REQ-023 SHALL make writes when full legal only as overwrites; a full array has no invalid addresses, so count stays DEPTH.

Reset
REQ-024 SHALL, on clk edge with rst=1, set all valid bits=0, count=0, rd_data=0, rd_valid=0, rd_hit=0 and wr_overwrite=0, giving empty=1 and full=0; memory contents are not cleared.
REQ-025 SHALL give rst priority over clr, wr_en and rd_en; rst asserted mid-operation discards any in-flight read result (rd_valid=0 on the cycle after reset).

Verification (ADDR_W=5, DATA_W=8, RD_CLEAR=1, WR_FIRST=0 unless stated)
REQ-026 SHALL cover: reset, then write 0xA5 @3, then read @3 -> the cycle after the read, rd_valid=1, rd_hit=1, rd_data=0xA5; count goes 0->1->0; empty goes 1->0->1.
REQ-027 SHALL cover: write all 32 addresses, then write 0x11 @7 -> count=32, full=1, wr_overwrite=1 the cycle after the 0x11 write, count stays 32.
REQ-028 SHALL cover: read @9 never written -> rd_valid=1, rd_hit=0, rd_data=0, count unchanged.
REQ-029 SHALL cover: @5 valid holding 0x22, same-cycle write 0x33 @5 and read @5 -> WR_FIRST=0 gives rd_data=0x22 with hit=1, WR_FIRST=1 gives rd_data=0x33; in both cases valid[5]=1 and count unchanged.
REQ-030 SHALL cover: count=10, clr with simultaneous write @0 -> count=0, empty=1, and a read @0 afterwards returns rd_hit=0.
REQ-031 SHALL cover: rd_en @3 while rst=1 in the following cycle -> rd_valid=0 and count=0 after reset; RD_CLEAR=0 variant where 3 reads of a valid entry leave count unchanged.

Source files
------------

// File: rtl/ram_tracked.sv
// ram_tracked: single-clock RAM with a valid bit per entry, an occupancy count,
// a registered 1-cycle read port and an optional read-to-invalidate mode.
module ram_tracked #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int RD_CLEAR = 1,
    parameter int WR_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              clr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_hit,
    output logic              wr_overwrite,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid;

    logic              same_addr_p0;
    logic              inc_p0;
    logic              dec_p0;
    logic              hit_p0;
    logic [DATA_W-1:0] data_p0;
    logic [ADDR_W:0]   count_next_p0;

    // Stage p0: decode this cycle's request against the current valid bits.
    // A read of the address being written keeps the entry valid, so it never
    // decrements the count; a write to an already-valid entry never increments it.
    always_comb begin
        same_addr_p0  = wr_en && (wr_addr == rd_addr);
        inc_p0        = wr_en && !valid[wr_addr];
        dec_p0        = rd_en && (RD_CLEAR != 0) && valid[rd_addr] && !same_addr_p0;
        count_next_p0 = count + {{ADDR_W{1'b0}}, inc_p0} - {{ADDR_W{1'b0}}, dec_p0};
        if (same_addr_p0 && (WR_FIRST != 0)) begin
            hit_p0  = 1'b1;
            data_p0 = wr_data;
        end else begin
            hit_p0  = valid[rd_addr];
            data_p0 = valid[rd_addr] ? mem[rd_addr] : '0;
        end
    end

    // Storage array: contents survive rst and clr; requests are ignored in those cycles.
    always_ff @(posedge clk) begin
        if (wr_en && !rst && !clr) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Valid bits: the write is applied after the read-clear so a colliding write wins.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            valid <= '0;
        end else begin
            if (rd_en && (RD_CLEAR != 0)) begin
                valid[rd_addr] <= 1'b0;
            end
            if (wr_en) begin
                valid[wr_addr] <= 1'b1;
            end
        end
    end

    // Occupancy count: bounded by construction, an increment needs a free entry
    // and a decrement needs a valid one.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else begin
            count <= count_next_p0;
        end
    end

    // Stage p1: registered read result and overwrite pulse; data/hit hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data      <= '0;
            rd_hit       <= 1'b0;
            rd_valid     <= 1'b0;
            wr_overwrite <= 1'b0;
        end else if (clr) begin
            rd_valid     <= 1'b0;
            wr_overwrite <= 1'b0;
        end else begin
            rd_valid     <= rd_en;
            wr_overwrite <= wr_en && valid[wr_addr];
            if (rd_en) begin
                rd_data <= data_p0;
                rd_hit  <= hit_p0;
            end
        end
    end

    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);

endmodule

// File: tb/tb_ram_tracked.sv
// Bench for ram_tracked: three instances (default, write-first, non-destructive
// read) share one stimulus stream and are compared against an array model.
module tb_ram_tracked;

    logic       clk = 1'b0;
    logic       rst, wr_en, rd_en, clr;
    logic [4:0] wr_addr, rd_addr;
    logic [7:0] wr_data;

    logic [7:0] rdata [3];
    logic       rdv   [3];
    logic       rhit  [3];
    logic       wow   [3];
    logic [5:0] cnt   [3];
    logic       emp   [3];
    logic       ful   [3];

    int total  = 0;
    int passed = 0;

    // model state per configuration: 0 = default, 1 = WR_FIRST=1, 2 = RD_CLEAR=0
    bit         cfg_rdclr [3] = '{1'b1, 1'b1, 1'b0};
    bit         cfg_wrfst [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] m_mem [3][32];
    bit         m_val [3][32];
    logic [7:0] e_data [3];
    bit         e_rdv [3];
    bit         e_hit [3];
    bit         e_ow  [3];

    always #5 clk = ~clk;

    ram_tracked #(.DATA_W(8), .ADDR_W(5), .RD_CLEAR(1), .WR_FIRST(0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .clr(clr), .rd_data(rdata[0]),
        .rd_valid(rdv[0]), .rd_hit(rhit[0]), .wr_overwrite(wow[0]), .count(cnt[0]),
        .empty(emp[0]), .full(ful[0]));

    ram_tracked #(.DATA_W(8), .ADDR_W(5), .RD_CLEAR(1), .WR_FIRST(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .clr(clr), .rd_data(rdata[1]),
        .rd_valid(rdv[1]), .rd_hit(rhit[1]), .wr_overwrite(wow[1]), .count(cnt[1]),
        .empty(emp[1]), .full(ful[1]));

    ram_tracked #(.DATA_W(8), .ADDR_W(5), .RD_CLEAR(0), .WR_FIRST(0)) dut2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .clr(clr), .rd_data(rdata[2]),
        .rd_valid(rdv[2]), .rd_hit(rhit[2]), .wr_overwrite(wow[2]), .count(cnt[2]),
        .empty(emp[2]), .full(ful[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int occupancy(input int k);
        int n = 0;
        for (int a = 0; a < 32; a++) n += m_val[k][a] ? 1 : 0;
        return n;
    endfunction

    // one clock: drive inputs, advance the model, then compare every instance
    task automatic cycle(input logic w, input logic [4:0] wa, input logic [7:0] wd,
                         input logic r, input logic [4:0] ra, input logic c, input logic rs);
        wr_en = w; wr_addr = wa; wr_data = wd;
        rd_en = r; rd_addr = ra; clr = c; rst = rs;
        for (int k = 0; k < 3; k++) begin
            if (rs) begin
                for (int a = 0; a < 32; a++) m_val[k][a] = 1'b0;
                e_rdv[k] = 0; e_hit[k] = 0; e_data[k] = 8'h00; e_ow[k] = 0;
            end else if (c) begin
                for (int a = 0; a < 32; a++) m_val[k][a] = 1'b0;
                e_rdv[k] = 0; e_ow[k] = 0;
            end else begin
                e_ow[k]  = w && m_val[k][wa];
                e_rdv[k] = r;
                if (r) begin
                    if (w && wa == ra && cfg_wrfst[k]) begin
                        e_hit[k] = 1; e_data[k] = wd;
                    end else begin
                        e_hit[k]  = m_val[k][ra];
                        e_data[k] = m_val[k][ra] ? m_mem[k][ra] : 8'h00;
                    end
                    if (cfg_rdclr[k]) m_val[k][ra] = 1'b0;
                end
                if (w) begin
                    m_val[k][wa] = 1'b1;
                    m_mem[k][wa] = wd;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            int n = occupancy(k);
            chk($sformatf("c%0d rd_valid", k), 32'(rdv[k]), 32'(e_rdv[k]));
            chk($sformatf("c%0d rd_hit", k), 32'(rhit[k]), 32'(e_hit[k]));
            chk($sformatf("c%0d rd_data", k), 32'(rdata[k]), 32'(e_data[k]));
            chk($sformatf("c%0d wr_overwrite", k), 32'(wow[k]), 32'(e_ow[k]));
            chk($sformatf("c%0d count", k), 32'(cnt[k]), 32'(n));
            chk($sformatf("c%0d empty", k), 32'(emp[k]), 32'(n == 0));
            chk($sformatf("c%0d full", k), 32'(ful[k]), 32'(n == 32));
        end
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            for (int a = 0; a < 32; a++) begin
                m_val[k][a] = 1'b0;
                m_mem[k][a] = 8'h00;
            end
        end
        rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;

        // reset
        cycle(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1);
        cycle(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1);
        chk("reset count", 32'(cnt[0]), 32'd0);
        chk("reset empty", 32'(emp[0]), 32'd1);
        chk("reset full", 32'(ful[0]), 32'd0);

        // write 0xA5 @3 then read it back
        cycle(1'b1, 5'd3, 8'hA5, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("wr3 count", 32'(cnt[0]), 32'd1);
        chk("wr3 empty", 32'(emp[0]), 32'd0);
        cycle(1'b0, 5'd0, 8'h00, 1'b1, 5'd3, 1'b0, 1'b0);
        chk("rd3 data", 32'(rdata[0]), 32'hA5);
        chk("rd3 hit", 32'(rhit[0]), 32'd1);
        chk("rd3 count", 32'(cnt[0]), 32'd0);
        chk("rd3 empty", 32'(emp[0]), 32'd1);
        idle();
        chk("idle holds data", 32'(rdata[0]), 32'hA5);

        // read of a never-written address
        cycle(1'b0, 5'd0, 8'h00, 1'b1, 5'd9, 1'b0, 1'b0);
        chk("rd9 hit", 32'(rhit[0]), 32'd0);
        chk("rd9 data", 32'(rdata[0]), 32'h00);

        // fill every address, then overwrite @7 while full
        for (int a = 0; a < 32; a++)
            cycle(1'b1, 5'(a), 8'($urandom_range(255)), 1'b0, 5'd0, 1'b0, 1'b0);
        chk("fill full", 32'(ful[0]), 32'd1);
        cycle(1'b1, 5'd7, 8'h11, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("ovw pulse", 32'(wow[0]), 32'd1);
        chk("ovw count", 32'(cnt[0]), 32'd32);

        // same-address collision @5
        cycle(1'b1, 5'd5, 8'h22, 1'b0, 5'd0, 1'b0, 1'b0);
        cycle(1'b1, 5'd5, 8'h33, 1'b1, 5'd5, 1'b0, 1'b0);
        chk("coll rf data", 32'(rdata[0]), 32'h22);
        chk("coll rf hit", 32'(rhit[0]), 32'd1);
        chk("coll wf data", 32'(rdata[1]), 32'h33);
        chk("coll count", 32'(cnt[0]), 32'd32);

        // non-destructive reads leave the count alone
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 5'd0, 8'h00, 1'b1, 5'd5, 1'b0, 1'b0);
        chk("rdclr0 count", 32'(cnt[2]), 32'd32);
        chk("rdclr0 data", 32'(rdata[2]), 32'h33);

        // count 10, then clr together with a write @0
        cycle(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0);
        for (int a = 0; a < 10; a++)
            cycle(1'b1, 5'(a), 8'(a + 8'h40), 1'b0, 5'd0, 1'b0, 1'b0);
        chk("ten count", 32'(cnt[0]), 32'd10);
        cycle(1'b1, 5'd0, 8'h77, 1'b0, 5'd0, 1'b1, 1'b0);
        chk("clr count", 32'(cnt[0]), 32'd0);
        chk("clr empty", 32'(emp[0]), 32'd1);
        cycle(1'b0, 5'd0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b0);
        chk("clr rd0 hit", 32'(rhit[0]), 32'd0);

        // reset right after a read discards the read result
        cycle(1'b1, 5'd3, 8'h5A, 1'b0, 5'd0, 1'b0, 1'b0);
        cycle(1'b0, 5'd0, 8'h00, 1'b1, 5'd3, 1'b0, 1'b0);
        cycle(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1);
        chk("rst rd_valid", 32'(rdv[0]), 32'd0);
        chk("rst count", 32'(cnt[2]), 32'd0);

        // randomized traffic over a narrow address window to force collisions
        for (int i = 0; i < 400; i++) begin
            logic       w, r, c, rs;
            logic [4:0] wa, ra;
            w  = 1'($urandom_range(1));
            r  = 1'($urandom_range(1));
            c  = ($urandom_range(40) == 0);
            rs = ($urandom_range(80) == 0);
            wa = (i < 200) ? 5'($urandom_range(7)) : 5'($urandom_range(31));
            ra = (i < 200) ? 5'($urandom_range(7)) : 5'($urandom_range(31));
            cycle(w, wa, 8'($urandom_range(255)), r, ra, c, rs);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
